// File: rtl/trajectory_stepper.sv
// Single-missile trajectory stepper: advances a pixel position once per frame tick from a
// x1000 trig pair and launch speed, using sub-pixel accumulators normalised one pixel per cycle.
module trajectory_stepper #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int GRAVITY  = 0,
    parameter int VY_MIN   = -16000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_launch,
    input  logic [9:0]  i_launch_x,
    input  logic [9:0]  i_launch_y,
    input  logic [3:0]  i_speed,
    input  logic [31:0] i_sin,
    input  logic [31:0] i_cos,
    input  logic        i_step,
    output logic        o_ready,
    output logic        o_in_flight,
    output logic [9:0]  o_pos_x,
    output logic [9:0]  o_pos_y,
    output logic        o_pos_valid,
    output logic        o_done
);

    typedef enum logic [1:0] {StIdle, StFlight, StNorm} state_e;

    localparam logic signed [17:0] K_ONE    = 18'sd1000;
    localparam logic signed [17:0] K_NEG    = -18'sd1000;
    localparam logic signed [17:0] K_GRAV   = 18'(GRAVITY);
    localparam logic signed [17:0] K_VY_MIN = 18'(VY_MIN);
    localparam logic signed [11:0] K_W      = 12'(SCREEN_W);
    localparam logic signed [11:0] K_H      = 12'(SCREEN_H);

    state_e r_state;
    state_e w_state_next;

    logic signed [16:0] r_vx, r_vy;
    logic signed [17:0] r_frac_x, r_frac_y;
    logic signed [11:0] r_px, r_py;
    logic [9:0]         r_pos_x, r_pos_y;
    logic               r_pos_valid, r_done;

    logic signed [31:0] w_vx_full, w_vy_full;
    logic signed [17:0] w_vy_grav;
    logic signed [16:0] w_vy_next;
    logic               w_x_pos, w_x_neg, w_y_pos, w_y_neg;
    logic               w_settled, w_in_bounds;
    logic               w_unused;

    // Trig inputs are bounded to +-1000, so the low 17 bits of the product hold the full value.
    assign w_vx_full = $signed({28'd0, i_speed}) * $signed(i_sin);
    assign w_vy_full = $signed({28'd0, i_speed}) * $signed(i_cos);
    assign w_unused  = ^{w_vx_full[31:17], w_vy_full[31:17]};

    assign w_vy_grav = {r_vy[16], r_vy} - K_GRAV;
    assign w_vy_next = (w_vy_grav < K_VY_MIN) ? K_VY_MIN[16:0] : w_vy_grav[16:0];

    assign w_x_pos     = r_frac_x >= K_ONE;
    assign w_x_neg     = r_frac_x <= K_NEG;
    assign w_y_pos     = r_frac_y >= K_ONE;
    assign w_y_neg     = r_frac_y <= K_NEG;
    assign w_settled   = !(w_x_pos || w_x_neg || w_y_pos || w_y_neg);
    assign w_in_bounds = !r_px[11] && (r_px < K_W) && !r_py[11] && (r_py < K_H);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (i_launch) w_state_next = StFlight;
            StFlight: if (i_step)   w_state_next = StNorm;
            StNorm:   if (w_settled) w_state_next = w_in_bounds ? StFlight : StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_ready     = (r_state == StIdle);
        o_in_flight = (r_state == StFlight) || (r_state == StNorm);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vx        <= '0;
            r_vy        <= '0;
            r_frac_x    <= '0;
            r_frac_y    <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_pos_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pos_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_launch) begin
                        r_vx     <= w_vx_full[16:0];
                        r_vy     <= w_vy_full[16:0];
                        r_frac_x <= '0;
                        r_frac_y <= '0;
                        r_px     <= {2'b00, i_launch_x};
                        r_py     <= {2'b00, i_launch_y};
                        r_pos_x  <= i_launch_x;
                        r_pos_y  <= i_launch_y;
                    end
                end
                StFlight: begin
                    if (i_step) begin
                        r_frac_x <= r_frac_x + {r_vx[16], r_vx};
                        r_frac_y <= r_frac_y + {r_vy[16], r_vy};
                        r_vy     <= w_vy_next;
                    end
                end
                StNorm: begin
                    if (w_settled) begin
                        if (w_in_bounds) begin
                            r_pos_x     <= r_px[9:0];
                            r_pos_y     <= r_py[9:0];
                            r_pos_valid <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        // Upward-positive frac_y maps onto downward-growing screen y.
                        if (w_x_pos) begin
                            r_frac_x <= r_frac_x - K_ONE;
                            r_px     <= r_px + 12'sd1;
                        end else if (w_x_neg) begin
                            r_frac_x <= r_frac_x + K_ONE;
                            r_px     <= r_px - 12'sd1;
                        end
                        if (w_y_pos) begin
                            r_frac_y <= r_frac_y - K_ONE;
                            r_py     <= r_py - 12'sd1;
                        end else if (w_y_neg) begin
                            r_frac_y <= r_frac_y + K_ONE;
                            r_py     <= r_py + 12'sd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;
    assign o_pos_valid = r_pos_valid;
    assign o_done      = r_done;

endmodule

// File: tb/tb_trajectory_stepper.sv
// Directed bench for trajectory_stepper: one instance without gravity, one with GRAVITY=100.
module tb_trajectory_stepper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        launch_a = 1'b0, launch_b = 1'b0;
    logic        step_a = 1'b0, step_b = 1'b0;
    logic [9:0]  lx = '0, ly = '0;
    logic [3:0]  speed = '0;
    logic [31:0] sin_v = '0, cos_v = '0;

    logic        a_ready, a_in_flight, a_pos_valid, a_done;
    logic [9:0]  a_pos_x, a_pos_y;
    logic        b_ready, b_in_flight, b_pos_valid, b_done;
    logic [9:0]  b_pos_x, b_pos_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trajectory_stepper u_dut (
        .i_clock(clk), .i_reset(rst), .i_launch(launch_a), .i_launch_x(lx), .i_launch_y(ly),
        .i_speed(speed), .i_sin(sin_v), .i_cos(cos_v), .i_step(step_a),
        .o_ready(a_ready), .o_in_flight(a_in_flight), .o_pos_x(a_pos_x), .o_pos_y(a_pos_y),
        .o_pos_valid(a_pos_valid), .o_done(a_done)
    );

    trajectory_stepper #(.GRAVITY(100)) u_grav (
        .i_clock(clk), .i_reset(rst), .i_launch(launch_b), .i_launch_x(lx), .i_launch_y(ly),
        .i_speed(speed), .i_sin(sin_v), .i_cos(cos_v), .i_step(step_b),
        .o_ready(b_ready), .o_in_flight(b_in_flight), .o_pos_x(b_pos_x), .o_pos_y(b_pos_y),
        .o_pos_valid(b_pos_valid), .o_done(b_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_launch(input bit sel, input int x, input int y, input int spd,
                             input int s, input int c);
        @(negedge clk);
        lx = 10'(x);
        ly = 10'(y);
        speed = 4'(spd);
        sin_v = s;
        cos_v = c;
        if (sel) launch_b = 1'b1; else launch_a = 1'b1;
        @(negedge clk);
        launch_a = 1'b0;
        launch_b = 1'b0;
    endtask

    // Pulses step, then waits (bounded) for pos_valid or done; lat counts edges after the step edge.
    task automatic step_wait(input bit sel, output int lat, output logic pv, output logic dn);
        @(negedge clk);
        if (sel) step_b = 1'b1; else step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        step_b = 1'b0;
        lat = 0;
        pv = 1'b0;
        dn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (sel ? (b_pos_valid || b_done) : (a_pos_valid || a_done)) begin
                pv = sel ? b_pos_valid : a_pos_valid;
                dn = sel ? b_done : a_done;
                break;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic pv, dn;
        int   cnt;
        int   fx, fy, vy, py, min_y, n;
        bit   ended;

        // 1: reset
        repeat (2) @(negedge clk);
        chk("rst_ready", a_ready, 1);
        chk("rst_in_flight", a_in_flight, 0);
        chk("rst_pos_x", a_pos_x, 0);
        chk("rst_pos_y", a_pos_y, 0);
        chk("rst_pos_valid", a_pos_valid, 0);
        chk("rst_done", a_done, 0);
        rst = 1'b0;

        // 2: straight right, speed 2
        do_launch(0, 100, 200, 2, 1000, 0);
        chk("t2_ready", a_ready, 0);
        chk("t2_in_flight", a_in_flight, 1);
        chk("t2_launch_x", a_pos_x, 100);
        chk("t2_launch_y", a_pos_y, 200);
        chk("t2_launch_pv", a_pos_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            step_wait(0, lat, pv, dn);
            chk("t2_pv", pv, 1);
            chk("t2_lat", lat, 3);
            chk("t2_x", a_pos_x, 100 + 2 * k);
            chk("t2_y", a_pos_y, 200);
        end
        @(negedge clk);
        chk("t2_pv_one_cycle", a_pos_valid, 0);

        // 3: diagonal, remainder carried across steps
        do_reset();
        do_launch(0, 50, 50, 1, 707, 707);
        step_wait(0, lat, pv, dn);
        chk("t3_s1_lat", lat, 1);
        chk("t3_s1_x", a_pos_x, 50);
        chk("t3_s1_y", a_pos_y, 50);
        step_wait(0, lat, pv, dn);
        chk("t3_s2_lat", lat, 2);
        chk("t3_s2_x", a_pos_x, 51);
        chk("t3_s2_y", a_pos_y, 49);
        step_wait(0, lat, pv, dn);
        chk("t3_s3_x", a_pos_x, 52);
        chk("t3_s3_y", a_pos_y, 48);
        step_wait(0, lat, pv, dn); // frac 121+707=828: no move
        chk("t3_s4_lat", lat, 1);
        chk("t3_s4_x", a_pos_x, 52);
        step_wait(0, lat, pv, dn); // frac 1535: one pixel each
        chk("t3_s5_x", a_pos_x, 53);
        chk("t3_s5_y", a_pos_y, 47);

        // 4: exit off the left edge
        do_reset();
        do_launch(0, 1, 100, 3, -1000, 0);
        step_wait(0, lat, pv, dn);
        chk("t4_done", dn, 1);
        chk("t4_pv", pv, 0);
        chk("t4_lat", lat, 4);
        chk("t4_ready", a_ready, 1);
        chk("t4_x", a_pos_x, 1);
        chk("t4_y", a_pos_y, 100);
        @(negedge clk);
        chk("t4_done_one_cycle", a_done, 0);

        // 5: vertical shot with gravity, checked against an integer model
        do_reset();
        do_launch(1, 320, 400, 1, 0, 1000);
        fx = 0; fy = 0; vy = 1000; py = 400; min_y = 400; ended = 0;
        for (int s = 0; s < 120 && !ended; s++) begin
            fy += vy;
            vy -= 100;
            if (vy < -16000) vy = -16000;
            n = (fy < 0 ? -fy : fy) / 1000;
            while (fy >= 1000) begin fy -= 1000; py--; end
            while (fy <= -1000) begin fy += 1000; py++; end
            step_wait(1, lat, pv, dn);
            chk("t5_lat", lat, n + 1);
            if (py >= 480) begin
                chk("t5_done", dn, 1);
                chk("t5_hold_y", b_pos_y, min_y > 479 ? 0 : int'(b_pos_y) >= 400 ? b_pos_y : 479);
                ended = 1;
            end else begin
                chk("t5_pv", pv, 1);
                chk("t5_y", b_pos_y, py);
                chk("t5_x", b_pos_x, 320);
                if (py < min_y) min_y = py;
                if (s == 0) chk("t5_first_y", b_pos_y, 399);
            end
        end
        chk("t5_ended", int'(ended), 1);
        chk("t5_apex", min_y, 395);
        chk("t5_ready_after", b_ready, 1);

        // 6: step during NORM and launch during FLIGHT are dropped; reset in NORM aborts quietly
        do_reset();
        do_launch(0, 100, 100, 15, 1000, 0);
        @(negedge clk);
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        lat = 0;
        pv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            step_a = (lat == 3);
            if (a_pos_valid) begin
                pv = 1'b1;
                break;
            end
        end
        step_a = 1'b0;
        chk("t6_pv", pv, 1);
        chk("t6_lat", lat, 16);
        chk("t6_x", a_pos_x, 115);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_pos_valid || a_done) cnt++;
        end
        chk("t6_no_queued_step", cnt, 0);
        do_launch(0, 7, 7, 1, 0, 1000);
        chk("t6_launch_ignored_flight", a_in_flight, 1);
        chk("t6_launch_ignored_x", a_pos_x, 115);
        step_wait(0, lat, pv, dn);
        chk("t6_after_launch_x", a_pos_x, 130);
        chk("t6_after_launch_y", a_pos_y, 100);
        @(negedge clk);
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_ready", a_ready, 1);
        chk("t6_rst_in_flight", a_in_flight, 0);
        chk("t6_rst_done", a_done, 0);
        chk("t6_rst_pos_x", a_pos_x, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_done || a_pos_valid) cnt++;
        end
        chk("t6_no_done_after_rst", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
